// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encoding, port indices and range helper for the dmem arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arbStateT;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int MEM_DEPTH = 32;

  function automatic logic addrInRange(input logic [31:0] addr, input int depth);
    return addr < 32'(depth);
  endfunction

  function automatic arbStateT ownState(input logic port);
    return (port == PORT1) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - two requester ports plus the single-port memory bus
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              p0_req;
  logic              p0_we;
  logic              p0_lock;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_err;

  logic              p1_req;
  logic              p1_we;
  logic              p1_lock;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational 2-way winner select honouring lock owner and round-robin pointer
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arbStateT   state,
  input  logic       rrPtr,
  output logic [1:0] gnt,
  output logic       winner
);

  always_comb begin
    gnt    = 2'b00;
    winner = PORT0;
    // A locked owner that still requests always wins; otherwise plain round-robin.
    if (state == OWN0 && req[0]) begin
      winner = PORT0;
    end else if (state == OWN1 && req[1]) begin
      winner = PORT1;
    end else if (req[0] && req[1]) begin
      winner = rrPtr;
    end else begin
      winner = req[1];
    end
    if (|req) begin
      gnt[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter with bounded lock in front of a single-port data memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = MEM_DEPTH,
  parameter int MAX_LOCK = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int LCW = $clog2(MAX_LOCK + 1);

  arbStateT          state;
  arbStateT          stateNext;
  logic              rrPtr;
  logic              rrNext;
  logic [LCW-1:0]    lockCnt;
  logic [LCW-1:0]    lockNext;
  logic [LCW-1:0]    newCnt;

  logic [1:0]        pickGnt;
  logic [1:0]        gnt;
  logic              winner;
  logic              anyGnt;
  logic              winWe;
  logic              winLock;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] winWdata;
  logic              winInRange;

  logic              rvalidQ [2];
  logic              errQ    [2];
  logic [DATA_W-1:0] rdataQ  [2];

  dmem_arb_pick uPick (
    .req    ({bus.p1_req, bus.p0_req}),
    .state  (state),
    .rrPtr  (rrPtr),
    .gnt    (pickGnt),
    .winner (winner)
  );

  // Reset masks every grant so nothing reaches memory while reset is held.
  assign gnt        = reset ? 2'b00 : pickGnt;
  assign anyGnt     = |gnt;
  assign winWe      = winner ? bus.p1_we    : bus.p0_we;
  assign winLock    = winner ? bus.p1_lock  : bus.p0_lock;
  assign winAddr    = winner ? bus.p1_addr  : bus.p0_addr;
  assign winWdata   = winner ? bus.p1_wdata : bus.p0_wdata;
  assign winInRange = addrInRange(32'(winAddr), DEPTH);

  assign bus.p0_gnt    = gnt[0];
  assign bus.p1_gnt    = gnt[1];
  assign bus.mem_addr  = anyGnt ? winAddr  : '0;
  assign bus.mem_wdata = anyGnt ? winWdata : '0;
  assign bus.mem_read  = anyGnt & winInRange & ~winWe;
  assign bus.mem_write = anyGnt & winInRange & winWe;

  assign bus.p0_rvalid = rvalidQ[0];
  assign bus.p0_err    = errQ[0];
  assign bus.p0_rdata  = rdataQ[0];
  assign bus.p1_rvalid = rvalidQ[1];
  assign bus.p1_err    = errQ[1];
  assign bus.p1_rdata  = rdataQ[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB;
      rrPtr   <= PORT0;
      lockCnt <= '0;
    end else begin
      state   <= stateNext;
      rrPtr   <= rrNext;
      lockCnt <= lockNext;
    end
  end

  always_comb begin
    stateNext = state;
    rrNext    = rrPtr;
    lockNext  = lockCnt;
    newCnt    = LCW'(1);
    if (anyGnt) begin
      rrNext = ~winner;
      // Continuing owner extends its streak; any other grant starts a fresh one.
      newCnt = (state == ownState(winner)) ? lockCnt + 1'b1 : LCW'(1);
      if (winLock && newCnt < LCW'(MAX_LOCK)) begin
        stateNext = ownState(winner);
        lockNext  = newCnt;
      end else begin
        stateNext = ARB;
        lockNext  = '0;
      end
    end else begin
      stateNext = ARB;
      lockNext  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        rvalidQ[p] <= 1'b0;
        errQ[p]    <= 1'b0;
        rdataQ[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        rvalidQ[p] <= gnt[p];
        errQ[p]    <= gnt[p] & ~winInRange;
        if (gnt[p]) begin
          rdataQ[p] <= (winInRange && !winWe) ? bus.mem_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - vector table, corner sequences and randomized model check for dmem_arbiter
module tb_dmem_arbiter;

  localparam int MAX_LOCK = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic memInit = 1'b1;
  logic [7:0] tbMem [32];
  logic [7:0] refMem [32];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .DEPTH(32), .MAX_LOCK(MAX_LOCK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [7:0] initVal(input int i);
    return (i == 17) ? 8'hFF : 8'(i);
  endfunction

  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 32; i++) tbMem[i] <= initVal(i);
    end else if (bus.mem_write && bus.mem_addr < 8'd32) begin
      tbMem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = (bus.mem_addr < 8'd32) ? tbMem[bus.mem_addr[4:0]] : 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       r0, w0, l0;
    logic [7:0] a0, d0;
    logic       r1, w1, l1;
    logic [7:0] a1, d1;
    logic [1:0] eGnt;
    logic       eRd, eWr;
    logic [1:0] eRv, eErr;
    logic [7:0] eRdata;
  } vecT;

  function automatic vecT mk(input int r0, w0, l0, a0, d0, r1, w1, l1, a1, d1,
                             input int eGnt, eRd, eWr, eRv, eErr, eRdata);
    vecT v;
    v.r0 = 1'(r0); v.w0 = 1'(w0); v.l0 = 1'(l0); v.a0 = 8'(a0); v.d0 = 8'(d0);
    v.r1 = 1'(r1); v.w1 = 1'(w1); v.l1 = 1'(l1); v.a1 = 8'(a1); v.d1 = 8'(d1);
    v.eGnt = 2'(eGnt); v.eRd = 1'(eRd); v.eWr = 1'(eWr);
    v.eRv = 2'(eRv); v.eErr = 2'(eErr); v.eRdata = 8'(eRdata);
    return v;
  endfunction

  task automatic drive(input logic r0, w0, l0, input logic [7:0] a0, d0,
                       input logic r1, w1, l1, input logic [7:0] a1, d1);
    bus.p0_req = r0; bus.p0_we = w0; bus.p0_lock = l0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_we = w1; bus.p1_lock = l1; bus.p1_addr = a1; bus.p1_wdata = d1;
  endtask

  vecT vecs [20];

  logic       pReq [2];
  logic       pWe [2];
  logic       pLock [2];
  logic [7:0] pAddr [2];
  logic [7:0] pWdata [2];
  int mOwner, mStreak, mPref;

  initial begin
    for (int i = 0; i < 32; i++) refMem[i] = initVal(i);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state: request present during reset must not be granted
    @(negedge clk);
    drive(1, 0, 0, 8'd5, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_gnt0", 32'(bus.p0_gnt), 0);
    check("rst_mem_read", 32'(bus.mem_read), 0);
    @(posedge clk); #1;
    memInit = 1'b0;
    check("rst_rvalid0", 32'(bus.p0_rvalid), 0);
    check("rst_rvalid1", 32'(bus.p1_rvalid), 0);
    check("rst_rdata0", 32'(bus.p0_rdata), 0);
    check("rst_err1", 32'(bus.p1_err), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //           r0 w0 l0 a0 d0      r1 w1 l1 a1 d1      gnt rd wr rv err rdata
    vecs[0]  = mk(1, 0, 0, 5, 0,     0, 0, 0, 0, 0,      1, 1, 0, 1, 0, 5);
    vecs[1]  = mk(1, 0, 0, 3, 0,     1, 0, 0, 7, 0,      2, 1, 0, 2, 0, 7);
    vecs[2]  = mk(1, 0, 0, 3, 0,     0, 0, 0, 0, 0,      1, 1, 0, 1, 0, 3);
    vecs[3]  = mk(0, 0, 0, 0, 0,     1, 1, 0, 40, 8'h55, 2, 0, 0, 2, 2, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0,     0, 0, 0, 0, 0,      1, 1, 0, 1, 0, 0);
    for (int i = 5; i < 9; i++)
      vecs[i] = mk(1, 0, 0, 9, 0,    1, 0, 1, 2, 0,      2, 1, 0, 2, 0, 2);
    vecs[9]  = mk(1, 0, 0, 9, 0,     1, 0, 1, 2, 0,      1, 1, 0, 1, 0, 9);
    vecs[10] = mk(0, 0, 0, 0, 0,     1, 0, 1, 2, 0,      2, 1, 0, 2, 0, 2);
    vecs[11] = mk(1, 0, 1, 17, 0,    0, 0, 0, 0, 0,      1, 1, 0, 1, 0, 8'hFF);
    vecs[12] = mk(1, 1, 1, 17, 8'h3C, 1, 0, 0, 4, 0,     1, 0, 1, 1, 0, 0);
    vecs[13] = mk(1, 0, 0, 17, 0,    1, 0, 0, 4, 0,      1, 1, 0, 1, 0, 8'h3C);
    vecs[14] = mk(0, 0, 0, 0, 0,     1, 0, 0, 4, 0,      2, 1, 0, 2, 0, 4);
    vecs[15] = mk(0, 0, 0, 0, 0,     1, 1, 0, 20, 8'hAA, 2, 0, 1, 2, 0, 0);
    vecs[16] = mk(1, 0, 0, 20, 0,    0, 0, 0, 0, 0,      1, 1, 0, 1, 0, 8'hAA);
    vecs[17] = mk(1, 0, 0, 31, 0,    0, 0, 0, 0, 0,      1, 1, 0, 1, 0, 31);
    vecs[18] = mk(1, 0, 0, 32, 0,    0, 0, 0, 0, 0,      1, 0, 0, 1, 1, 0);
    vecs[19] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      vecT v;
      logic [7:0] wa;
      v = vecs[i];
      @(negedge clk);
      drive(v.r0, v.w0, v.l0, v.a0, v.d0, v.r1, v.w1, v.l1, v.a1, v.d1);
      #1;
      check($sformatf("v%0d_gnt0", i), 32'(bus.p0_gnt), 32'(v.eGnt[0]));
      check($sformatf("v%0d_gnt1", i), 32'(bus.p1_gnt), 32'(v.eGnt[1]));
      check($sformatf("v%0d_mem_read", i), 32'(bus.mem_read), 32'(v.eRd));
      check($sformatf("v%0d_mem_write", i), 32'(bus.mem_write), 32'(v.eWr));
      wa = v.eGnt[0] ? v.a0 : v.a1;
      if (v.eGnt != 2'b00) check($sformatf("v%0d_mem_addr", i), 32'(bus.mem_addr), 32'(wa));
      if (v.eWr) refMem[wa[4:0]] = v.eGnt[0] ? v.d0 : v.d1;
      @(posedge clk); #1;
      check($sformatf("v%0d_rvalid0", i), 32'(bus.p0_rvalid), 32'(v.eRv[0]));
      check($sformatf("v%0d_rvalid1", i), 32'(bus.p1_rvalid), 32'(v.eRv[1]));
      check($sformatf("v%0d_err0", i), 32'(bus.p0_err), 32'(v.eErr[0]));
      check($sformatf("v%0d_err1", i), 32'(bus.p1_err), 32'(v.eErr[1]));
      if (v.eRv[0]) check($sformatf("v%0d_rdata0", i), 32'(bus.p0_rdata), 32'(v.eRdata));
      if (v.eRv[1]) check($sformatf("v%0d_rdata1", i), 32'(bus.p1_rdata), 32'(v.eRdata));
    end

    // Reset in the middle of a locked write burst
    @(negedge clk);
    drive(1, 1, 1, 8'd10, 8'h11, 0, 0, 0, 0, 0);
    #1;
    check("burst_gnt0", 32'(bus.p0_gnt), 1);
    check("burst_mem_write", 32'(bus.mem_write), 1);
    refMem[10] = 8'h11;
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1, 1, 8'd11, 8'h77, 0, 0, 0, 0, 0);
    #1;
    check("rstmid_gnt0", 32'(bus.p0_gnt), 0);
    check("rstmid_mem_write", 32'(bus.mem_write), 0);
    @(posedge clk); #1;
    check("rstmid_mem11", 32'(tbMem[11]), 32'(refMem[11]));
    check("rstmid_rvalid0", 32'(bus.p0_rvalid), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 0, 8'd10, 0, 1, 0, 0, 8'd6, 0);
    #1;
    check("postrst_gnt0", 32'(bus.p0_gnt), 1);
    check("postrst_gnt1", 32'(bus.p1_gnt), 0);
    @(posedge clk); #1;
    check("postrst_rdata0", 32'(bus.p0_rdata), 32'(refMem[10]));

    // Continuous contention alternates, p0 having just been served
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1, 0, 0, 8'(k), 0, 1, 0, 0, 8'(k + 6), 0);
      #1;
      check($sformatf("alt%0d_gnt0", k), 32'(bus.p0_gnt), 32'(k % 2));
      check($sformatf("alt%0d_gnt1", k), 32'(bus.p1_gnt), 32'((k + 1) % 2));
      @(posedge clk);
    end

    // Randomized traffic against the reference model
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mOwner = -1; mStreak = 0; mPref = 0;
    for (int p = 0; p < 2; p++) pReq[p] = 1'b0;

    for (int c = 0; c < 400; c++) begin
      int w;
      logic inR;
      logic [7:0] expRdata;
      for (int p = 0; p < 2; p++) begin
        if (!pReq[p] && $urandom_range(3) != 0) begin
          pReq[p]   = 1'b1;
          pWe[p]    = 1'($urandom_range(1));
          pLock[p]  = ($urandom_range(2) != 0);
          pAddr[p]  = 8'($urandom_range(39));
          pWdata[p] = 8'($urandom);
        end
      end
      drive(pReq[0], pWe[0], pLock[0], pAddr[0], pWdata[0],
            pReq[1], pWe[1], pLock[1], pAddr[1], pWdata[1]);

      if (mOwner >= 0 && pReq[mOwner]) w = mOwner;
      else if (pReq[0] && pReq[1]) w = mPref;
      else if (pReq[0]) w = 0;
      else if (pReq[1]) w = 1;
      else w = -1;

      inR = 1'b0;
      expRdata = 8'h00;
      if (w >= 0) begin
        inR = (pAddr[w] < 8'd32);
        if (inR && !pWe[w]) expRdata = refMem[pAddr[w][4:0]];
      end
      #1;
      check($sformatf("r%0d_gnt0", c), 32'(bus.p0_gnt), 32'(w == 0));
      check($sformatf("r%0d_gnt1", c), 32'(bus.p1_gnt), 32'(w == 1));
      check($sformatf("r%0d_mem_read", c), 32'(bus.mem_read), 32'(w >= 0 && inR && !pWe[w]));
      check($sformatf("r%0d_mem_write", c), 32'(bus.mem_write), 32'(w >= 0 && inR && pWe[w]));
      if (w >= 0) begin
        check($sformatf("r%0d_mem_addr", c), 32'(bus.mem_addr), 32'(pAddr[w]));
        if (inR && pWe[w]) refMem[pAddr[w][4:0]] = pWdata[w];
        mPref = 1 - w;
        if (pLock[w]) begin
          mStreak = (mOwner == w) ? mStreak + 1 : 1;
          if (mStreak >= MAX_LOCK) begin mOwner = -1; mStreak = 0; end
          else mOwner = w;
        end else begin
          mOwner = -1; mStreak = 0;
        end
      end else begin
        mOwner = -1; mStreak = 0;
      end
      @(posedge clk); #1;
      check($sformatf("r%0d_rvalid0", c), 32'(bus.p0_rvalid), 32'(w == 0));
      check($sformatf("r%0d_rvalid1", c), 32'(bus.p1_rvalid), 32'(w == 1));
      if (w == 0) begin
        check($sformatf("r%0d_err0", c), 32'(bus.p0_err), 32'(!inR));
        check($sformatf("r%0d_rdata0", c), 32'(bus.p0_rdata), 32'(expRdata));
      end
      if (w == 1) begin
        check($sformatf("r%0d_err1", c), 32'(bus.p1_err), 32'(!inR));
        check($sformatf("r%0d_rdata1", c), 32'(bus.p1_rdata), 32'(expRdata));
      end
      if (w >= 0) pReq[w] = 1'b0;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
